// File: rtl/dmem_access_ctrl.sv
// RV32I load/store sequencer for a word-wide data memory without byte enables (SB/SH via read-modify-write).
// Latency: load/SW done 2 cycles after accept, SB/SH 3, plus one per ack wait cycle; requests while busy are dropped.
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_func3,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_fault,
  output logic                  cpu_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    we_q;
  logic [2:0]              func3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [7:0]              tmo_cnt;
  logic                    misaligned;
  logic                    tmo_hit;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             ld_data;
  logic [31:0]             st_merged;

  assign misaligned = (cpu_func3[1:0] == 2'b11) ||
                      (cpu_func3[1:0] == 2'b01 && cpu_addr[0]) ||
                      (cpu_func3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (misaligned)                              state_nxt = S_FAULT;
          else if (cpu_we && cpu_func3[1:0] == 2'b10)  state_nxt = S_WR;
          else                                         state_nxt = S_RD;
        end
      end
      // Stores reaching RD are sub-word: the read is the first half of the RMW.
      S_RD: begin
        if (mem_ack)      state_nxt = we_q ? S_WR : S_DONE;
        else if (tmo_hit) state_nxt = S_FAULT;
      end
      S_WR: begin
        if (mem_ack)      state_nxt = S_DONE;
        else if (tmo_hit) state_nxt = S_FAULT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    ld_byte   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data   = mem_rdata;
    st_merged = mem_rdata;
    case (func3_q[1:0])
      2'b00: begin
        ld_data = {{24{ld_byte[7] & ~func3_q[2]}}, ld_byte};
        st_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ld_data = {{16{ld_half[15] & ~func3_q[2]}}, ld_half};
        st_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ld_data   = mem_rdata;
        st_merged = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      func3_q   <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      tmo_cnt   <= 8'h0;
      mem_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            we_q      <= cpu_we;
            func3_q   <= cpu_func3;
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            tmo_cnt   <= 8'h0;
            mem_wdata <= cpu_wdata;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            if (we_q) begin
              mem_wdata <= st_merged;
              tmo_cnt   <= 8'h0;
            end else begin
              cpu_rdata <= ld_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_WR: begin
          if (!mem_ack) tmo_cnt <= tmo_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_busy  = (state != S_IDLE);
  assign mem_req   = (state == S_RD) || (state == S_WR);
  assign mem_we    = (state == S_WR);
  assign cpu_done  = (state == S_DONE) || (state == S_FAULT);
  assign cpu_fault = (state == S_FAULT);
  assign mem_addr  = addr_q[ADDR_WIDTH-1:2];

endmodule
